serial_pattern_tx: RTL and testbench

Parallel-to-serial pattern transmitter. It generates the serial `w` bit stream consumed by the team's Mealy sequence detectors. It accepts a WIDTH-bit word through a ready/start handshake and shifts it out MSB-first, one bit per clock, with a valid qualifier. While shifting, it counts adjacent-equal bit pairs inside the word (the events a two-in-a-row detector flags with `z`), so the bench and system logic get a reference count per word.

---
 rtl/serial_pattern_tx.sv | 120 ++++++++++++
 tb/tb_serial_pattern_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern transmitter: shifts a WIDTH-bit word out MSB-first
// with a valid qualifier, and counts the adjacent-equal bit pairs in each word.
// Word latency is WIDTH+2 cycles from accept to the end of the done pulse.
// Backpressure: ready is high only in IDLE, and start is ignored at other times.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  output logic             ready,
  output logic             w,
  output logic             w_valid,
  output logic             last,
  output logic             done,
  output logic [CW-1:0]    pair_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    run_cnt;
  logic [CW-1:0]    run_cnt_nxt;
  logic             prev_bit;
  logic             last_bit;
  logic             pair_hit;

  // State register; reset drops any word in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and output decode from the registered state
  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    w_valid     = 1'b0;
    w           = 1'b0;
    last        = 1'b0;
    done        = 1'b0;
    last_bit    = (bit_cnt == CW'(WIDTH - 1));
    pair_hit    = 1'b0;
    run_cnt_nxt = run_cnt;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_valid = 1'b1;
        w       = shreg[WIDTH-1];
        last    = last_bit;
        // The first bit of a word has no predecessor, so pairs never cross words
        pair_hit    = (bit_cnt != '0) && (shreg[WIDTH-1] == prev_bit);
        run_cnt_nxt = run_cnt + CW'(pair_hit);
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register, bit counter and pair counting datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      run_cnt    <= '0;
      prev_bit   <= 1'b0;
      pair_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= data_in;
            bit_cnt  <= '0;
            run_cnt  <= '0;
            prev_bit <= 1'b0;
          end
        end
        SHIFT: begin
          shreg    <= {shreg[WIDTH-2:0], 1'b0};
          prev_bit <= shreg[WIDTH-1];
          run_cnt  <= run_cnt_nxt;
          if (last_bit) begin
            bit_cnt    <= '0;
            pair_count <= run_cnt_nxt;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx with hand-computed expected streams and counts.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled there too.
// Every comparison goes through the check task.
module tb_serial_pattern_tx;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       start;
  logic       ready;
  logic       w;
  logic       w_valid;
  logic       last;
  logic       done;
  logic [2:0] pair_count;

  int n_checks;
  int n_fails;

  serial_pattern_tx #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .start      (start),
    .ready      (ready),
    .w          (w),
    .w_valid    (w_valid),
    .last       (last),
    .done       (done),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmit one word with a one-cycle start pulse and check every cycle.
  // With poke set, start is pulsed with other data during SHIFT and during DONE.
  task automatic run_word(input logic [7:0] d, input logic [2:0] exp_pc, input bit poke);
    data_in = d;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("bit_vld", w_valid, 1'b1);
      check("bit_w", w, d[7-i]);
      check("bit_last", last, (i == 7));
      check("bit_rdy", ready, 1'b0);
      data_in = poke ? 8'h55 : d;
      start   = poke && (i == 3);
      tick();
      start = 1'b0;
    end
    check("done_pulse", done, 1'b1);
    check("done_vld", w_valid, 1'b0);
    check("done_w", w, 1'b0);
    check("done_rdy", ready, 1'b0);
    check("done_pc", pair_count, exp_pc);
    start = poke;
    tick();
    start = 1'b0;
    check("idle_rdy", ready, 1'b1);
    check("idle_done", done, 1'b0);
    check("idle_pc", pair_count, exp_pc);
    if (poke) begin
      tick();
      check("poke_noacc_rdy", ready, 1'b1);
      check("poke_noacc_vld", w_valid, 1'b0);
    end
  endtask

  // Two words with start held high; cycle c counts from the first accept.
  task automatic back_to_back();
    logic [7:0] wa;
    logic [7:0] wb;
    logic       e_vld;
    logic       e_w;
    logic       e_done;
    wa = 8'hF0;
    wb = 8'h0F;
    data_in = wa;
    start   = 1'b1;
    tick();
    data_in = wb;
    for (int c = 0; c < 20; c++) begin
      e_vld  = (c < 8) || (c >= 10 && c < 18);
      e_w    = (c < 8) ? wa[7-c] : ((c >= 10 && c < 18) ? wb[17-c] : 1'b0);
      e_done = (c == 8) || (c == 18);
      check("b2b_vld", w_valid, e_vld);
      check("b2b_w", w, e_w);
      check("b2b_done", done, e_done);
      if (c >= 8) check("b2b_pc", pair_count, 3'd6);
      if (c == 10) start = 1'b0;
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    start    = 1'b0;
    data_in  = 8'h00;

    // Asynchronous reset before the first clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_rdy", ready, 1'b1);
    check("rst_vld", w_valid, 1'b0);
    check("rst_w", w, 1'b0);
    check("rst_last", last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pc", pair_count, 3'd0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    tick();
    check("idle_hold_rdy", ready, 1'b1);
    check("idle_hold_vld", w_valid, 1'b0);

    run_word(8'b1011_0011, 3'd3, 1'b0);
    run_word(8'hFF, 3'd7, 1'b0);
    run_word(8'hAA, 3'd0, 1'b0);
    run_word(8'h00, 3'd7, 1'b0);
    run_word(8'h3C, 3'd5, 1'b1);

    back_to_back();

    // Mid-word reset after three bits of 8'hFF
    data_in = 8'hFF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_bit_w", w, 1'b1);
      check("mid_bit_vld", w_valid, 1'b1);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_vld", w_valid, 1'b0);
    check("mid_rst_w", w, 1'b0);
    check("mid_rst_rdy", ready, 1'b1);
    check("mid_rst_pc", pair_count, 3'd0);
    @(posedge clk);
    #4 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid_no_done", done, 1'b0);
      check("mid_no_vld", w_valid, 1'b0);
    end
    run_word(8'h81, 3'd5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
